// File: rtl/aes_out_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : aes_out_packer
// Purpose  : Drains byte-per-word AES results and packs 4 bytes LE per output word.
// Revision : 1.0
// ---------------------------------------------------------------------------
module aes_out_packer #(
   parameter int DATA_WIDTH      = 32,
   parameter int BYTES_PER_BLOCK = 16
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  in_empty,
   output logic                  in_rd,
   input  logic [DATA_WIDTH-1:0] in_din,
   input  logic                  out_full,
   output logic                  out_wr,
   output logic [DATA_WIDTH-1:0] out_dout,
   output logic                  block_done,
   output logic [15:0]           block_count,
   output logic [15:0]           err_count
);

   localparam int C_WORDS = BYTES_PER_BLOCK / 4;
   localparam int C_IDX_W = (C_WORDS > 1) ? $clog2(C_WORDS) : 1;
   localparam logic [C_IDX_W-1:0] C_LAST_IDX = C_IDX_W'(C_WORDS - 1);

   typedef enum logic [1:0] {
      ST_COLLECT  = 2'd0,
      ST_POP_WAIT = 2'd1,
      ST_WRITE    = 2'd2
   } state_t;

   // Asynchronous assert, two-flop synchronous release.
   logic [1:0] r_rst_sync;
   logic       w_rst_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_rst_sync <= 2'b00;
      else          r_rst_sync <= {r_rst_sync[0], 1'b1};
   end

   assign w_rst_n = r_rst_sync[1];

   state_t                r_state, w_state_next;
   logic [1:0]            r_lane, w_lane_next;
   logic [C_IDX_W-1:0]    r_word_idx, w_word_idx_next;
   logic [DATA_WIDTH-1:0] r_pack, w_pack_next;
   logic                  r_lane3_filled, w_lane3_filled_next;
   logic                  r_in_rd, w_in_rd_next;
   logic                  r_out_wr, w_out_wr_next;
   logic [DATA_WIDTH-1:0] r_out_dout, w_out_dout_next;
   logic                  r_block_done, w_block_done_next;
   logic [15:0]           r_block_count, w_block_count_next;
   logic [15:0]           r_err_count, w_err_count_next;
   logic                  w_valid_byte;

   assign w_valid_byte = (in_din[DATA_WIDTH-1:8] == '0);

   always_ff @(posedge clock or negedge w_rst_n) begin
      if (!w_rst_n) begin
         r_state        <= ST_COLLECT;
         r_lane         <= 2'd0;
         r_word_idx     <= '0;
         r_pack         <= '0;
         r_lane3_filled <= 1'b0;
         r_in_rd        <= 1'b0;
         r_out_wr       <= 1'b0;
         r_out_dout     <= '0;
         r_block_done   <= 1'b0;
         r_block_count  <= 16'd0;
         r_err_count    <= 16'd0;
      end else begin
         r_state        <= w_state_next;
         r_lane         <= w_lane_next;
         r_word_idx     <= w_word_idx_next;
         r_pack         <= w_pack_next;
         r_lane3_filled <= w_lane3_filled_next;
         r_in_rd        <= w_in_rd_next;
         r_out_wr       <= w_out_wr_next;
         r_out_dout     <= w_out_dout_next;
         r_block_done   <= w_block_done_next;
         r_block_count  <= w_block_count_next;
         r_err_count    <= w_err_count_next;
      end
   end

   always_comb begin
      w_state_next        = r_state;
      w_lane_next         = r_lane;
      w_word_idx_next     = r_word_idx;
      w_pack_next         = r_pack;
      w_lane3_filled_next = r_lane3_filled;
      w_in_rd_next        = 1'b0;
      w_out_wr_next       = 1'b0;
      w_out_dout_next     = r_out_dout;
      w_block_done_next   = 1'b0;
      w_block_count_next  = r_block_count;
      w_err_count_next    = r_err_count;

      case (r_state)
         ST_COLLECT: begin
            if (!in_empty) begin
               w_in_rd_next        = 1'b1;
               w_state_next        = ST_POP_WAIT;
               w_lane3_filled_next = w_valid_byte && (r_lane == 2'd3);
               if (w_valid_byte) begin
                  w_pack_next[8*r_lane +: 8] = in_din[7:0];
                  w_lane_next                = r_lane + 2'd1;
               end else if (r_err_count != 16'hFFFF) begin
                  w_err_count_next = r_err_count + 16'd1;
               end
            end
         end
         // Gap cycle lets the FIFO empty flag catch up with the pop.
         ST_POP_WAIT: begin
            w_state_next = r_lane3_filled ? ST_WRITE : ST_COLLECT;
         end
         ST_WRITE: begin
            if (!out_full) begin
               w_out_wr_next   = 1'b1;
               w_out_dout_next = r_pack;
               w_pack_next     = '0;
               w_state_next    = ST_COLLECT;
               if (r_word_idx == C_LAST_IDX) begin
                  w_word_idx_next    = '0;
                  w_block_done_next  = 1'b1;
                  w_block_count_next = r_block_count + 16'd1;
               end else begin
                  w_word_idx_next = r_word_idx + C_IDX_W'(1);
               end
            end
         end
         default: w_state_next = ST_COLLECT;
      endcase
   end

   assign in_rd       = r_in_rd;
   assign out_wr      = r_out_wr;
   assign out_dout    = r_out_dout;
   assign block_done  = r_block_done;
   assign block_count = r_block_count;
   assign err_count   = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_aes_out_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_aes_out_packer
// Purpose  : Scoreboard bench for aes_out_packer with FWFT source model.
// Revision : 1.0
// ---------------------------------------------------------------------------
module tb_aes_out_packer;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        in_empty = 1'b1;
   logic [31:0] in_din = 32'd0;
   logic        out_full = 1'b0;
   logic        in_rd, out_wr, block_done;
   logic [31:0] out_dout;
   logic [15:0] block_count, err_count;

   aes_out_packer #(.DATA_WIDTH(32), .BYTES_PER_BLOCK(16)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .in_empty   (in_empty),
      .in_rd      (in_rd),
      .in_din     (in_din),
      .out_full   (out_full),
      .out_wr     (out_wr),
      .out_dout   (out_dout),
      .block_done (block_done),
      .block_count(block_count),
      .err_count  (err_count)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] data;
      logic        done;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] src_q[$];
   int          n_cmp = 0;
   int          n_err = 0;

   int          m_lane = 0;
   int          m_widx = 0;
   logic [31:0] m_pack = 32'd0;
   logic [15:0] m_blocks = 16'd0;
   logic [15:0] m_errs = 16'd0;
   logic        prev_rd = 1'b0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic refresh_src();
      in_empty = (src_q.size() == 0);
      in_din   = in_empty ? 32'd0 : src_q[0];
   endtask

   // Byte-level reference: every 4th valid byte completes one expected word.
   task automatic push_word(input logic [31:0] w);
      logic d;
      src_q.push_back(w);
      refresh_src();
      if (w[31:8] == 24'd0) begin
         m_pack[8*m_lane +: 8] = w[7:0];
         m_lane++;
         if (m_lane == 4) begin
            d = (m_widx == 3);
            exp_q.push_back('{data: m_pack, done: d});
            m_pack = 32'd0;
            m_lane = 0;
            m_widx = d ? 0 : m_widx + 1;
         end
      end else if (m_errs != 16'hFFFF) begin
         m_errs = m_errs + 16'd1;
      end
   endtask

   task automatic model_clear();
      exp_q.delete();
      src_q.delete();
      refresh_src();
      m_lane   = 0;
      m_widx   = 0;
      m_pack   = 32'd0;
      m_blocks = 16'd0;
      m_errs   = 16'd0;
   endtask

   task automatic check_zero(input string pfx);
      check({pfx, "_in_rd"},       32'(in_rd),       32'd0);
      check({pfx, "_out_wr"},      32'(out_wr),      32'd0);
      check({pfx, "_out_dout"},    out_dout,         32'd0);
      check({pfx, "_block_done"},  32'(block_done),  32'd0);
      check({pfx, "_block_count"}, 32'(block_count), 32'd0);
      check({pfx, "_err_count"},   32'(err_count),   32'd0);
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int i = 0;
      while ((src_q.size() != 0 || exp_q.size() != 0) && i < budget) begin
         @(negedge clock);
         i++;
      end
      check({tag, "_drain"}, 32'(src_q.size() + exp_q.size()), 32'd0);
      repeat (3) @(negedge clock);
      check({tag, "_err_count"},   32'(err_count),   32'(m_errs));
      check({tag, "_block_count"}, 32'(block_count), 32'(m_blocks));
   endtask

   // FWFT source: pop lands between edges, after the registered strobe.
   always @(negedge clock) begin
      if (in_rd && src_q.size() > 0) begin
         void'(src_q.pop_front());
         refresh_src();
      end
   end

   always @(negedge clock) begin
      exp_t e;
      check("rd_back_to_back", 32'(in_rd & prev_rd), 32'd0);
      prev_rd = in_rd;
      if (out_wr) begin
         if (exp_q.size() == 0) begin
            check("spurious_wr", 32'(out_wr), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("out_dout",   out_dout,         e.data);
            check("block_done", 32'(block_done),  32'(e.done));
            if (e.done) m_blocks = m_blocks + 16'd1;
            check("block_count", 32'(block_count), 32'(m_blocks));
         end
      end else begin
         check("done_without_wr", 32'(block_done), 32'd0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(negedge clock);
      check_zero("reset");
      reset_n = 1'b1;
      repeat (4) @(negedge clock);

      // Basic block
      for (int i = 0; i < 16; i++) push_word(32'(i));
      wait_drain("basic", 200);

      // Backpressure: held word must stall both output and input
      out_full = 1'b1;
      for (int i = 16; i < 24; i++) push_word(32'(i));
      repeat (12) @(negedge clock);
      for (int i = 0; i < 10; i++) begin
         check("bp_hold_wr", 32'(out_wr), 32'd0);
         check("bp_hold_rd", 32'(in_rd),  32'd0);
         @(negedge clock);
      end
      out_full = 1'b0;
      @(negedge clock);
      check("bp_release_wr", 32'(out_wr), 32'd1);
      for (int i = 24; i < 32; i++) push_word(32'(i));
      wait_drain("backpressure", 200);

      // Malformed words interleaved between bytes
      push_word(32'h11);
      push_word(32'hC000_0000);
      push_word(32'h22);
      push_word(32'h0000_010A);
      push_word(32'h33);
      push_word(32'h44);
      for (int i = 0; i < 12; i++) push_word(32'h50 + 32'(i));
      wait_drain("malformed", 200);

      // Sparse input over two blocks
      for (int i = 0; i < 32; i++) begin
         push_word(32'h80 + 32'(i));
         repeat ($urandom_range(0, 20)) @(negedge clock);
      end
      wait_drain("sparse", 1000);

      // Asynchronous reset mid-block
      for (int i = 0; i < 6; i++) push_word(32'h60 + 32'(i));
      begin
         int k = 0;
         while (src_q.size() != 0 && k < 100) begin
            @(negedge clock);
            k++;
         end
      end
      repeat (4) @(negedge clock);
      @(posedge clock);
      #3;
      reset_n = 1'b0;
      model_clear();
      #1;
      check_zero("mid_reset");
      @(negedge clock);
      reset_n = 1'b1;
      repeat (4) @(negedge clock);
      for (int i = 0; i < 16; i++) push_word(32'hA0 + 32'(i));
      wait_drain("after_reset", 200);

      // Block counter wrap
      @(negedge clock);
      force dut.r_block_count = 16'hFFFF;
      #1;
      release dut.r_block_count;
      m_blocks = 16'hFFFF;
      check("wrap_preset", 32'(block_count), 32'h0000_FFFF);
      for (int i = 0; i < 16; i++) push_word(32'hB0 + 32'(i));
      wait_drain("wrap", 200);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
